// File: rtl/timer_ctrl_if.sv
// Request/counter bundle between the microcode sequencer, timer_ctrl and one delay counter.
// The abort/aborted pair exists only when TIMER_CTRL_ABORT_EN is defined.
interface timer_ctrl_if #(
  parameter int WIDTH      = 10,
  parameter int PRESCALE_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [WIDTH-1:0]      req_delay;
  logic [PRESCALE_W-1:0] req_prescale;
  logic                  busy;
  logic                  done;
  logic                  ctr_en;
  logic                  ctr_reset;
  logic [WIDTH-1:0]      ctr_threshold;
  logic                  ctr_finished;
`ifdef TIMER_CTRL_ABORT_EN
  logic                  abort;
  logic                  aborted;
`endif

  modport slave (
    input  req_valid, req_delay, req_prescale, ctr_finished,
`ifdef TIMER_CTRL_ABORT_EN
    input  abort,
    output aborted,
`endif
    output req_ready, busy, done, ctr_en, ctr_reset, ctr_threshold
  );

  modport master (
    output req_valid, req_delay, req_prescale, ctr_finished,
`ifdef TIMER_CTRL_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  req_ready, busy, done, ctr_en, ctr_reset, ctr_threshold
  );
endinterface

// File: rtl/timer_ctrl.sv
// Delay-counter initiator: takes a delay request, drives a prescaled tick into the counter, pulses done.
// Optional cancel path enabled by defining TIMER_CTRL_ABORT_EN.
module timer_ctrl #(
  parameter int WIDTH      = 10,
  parameter int PRESCALE_W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  timer_ctrl_if.slave  bus
);

`ifdef TIMER_CTRL_ABORT_EN
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DONE, ABORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
`endif

  state_t                r_state;
  state_t                w_next_state;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [WIDTH-1:0]      r_threshold;

  logic w_handshake;
  logic w_tick;
  logic w_ready;
  logic w_busy;
  logic w_done;
  logic w_en;
  logic w_rst;
`ifdef TIMER_CTRL_ABORT_EN
  logic w_aborted;
`endif

  assign w_handshake = bus.req_valid && w_ready;
  assign w_tick      = (r_cnt == r_prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_prescale  <= '0;
      r_threshold <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_handshake) begin
        r_threshold <= bus.req_delay;
        r_prescale  <= bus.req_prescale;
      end
      // Count restarts in CLEAR so the first tick lands P cycles into RUN.
      if (r_state == CLEAR) begin
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_cnt <= w_tick ? '0 : r_cnt + PRESCALE_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_en         = 1'b0;
    w_rst        = 1'b0;
`ifdef TIMER_CTRL_ABORT_EN
    w_aborted    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
        if (bus.req_valid) w_next_state = CLEAR;
      end
      CLEAR: begin
        w_en  = 1'b1;
        w_rst = 1'b1;
`ifdef TIMER_CTRL_ABORT_EN
        w_next_state = bus.abort ? ABORT : RUN;
`else
        w_next_state = RUN;
`endif
      end
      RUN: begin
        w_en = w_tick;
        // A finish arriving together with abort still completes normally.
        if (bus.ctr_finished) begin
          w_next_state = DONE;
`ifdef TIMER_CTRL_ABORT_EN
        end else if (bus.abort) begin
          w_next_state = ABORT;
`endif
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_en         = 1'b1;
        w_rst        = 1'b1;
        w_next_state = IDLE;
      end
`ifdef TIMER_CTRL_ABORT_EN
      ABORT: begin
        w_en         = 1'b1;
        w_rst        = 1'b1;
        w_aborted    = 1'b1;
        w_next_state = IDLE;
      end
`endif
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign bus.req_ready     = w_ready;
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.ctr_en        = w_en;
  assign bus.ctr_reset     = w_rst;
  assign bus.ctr_threshold = r_threshold;
`ifdef TIMER_CTRL_ABORT_EN
  assign bus.aborted       = w_aborted;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomised bench for timer_ctrl: an attached-counter model plus latency/tick-pattern expectations
// derived from the request parameters.
module tb_timer_ctrl;
  localparam int WIDTH = 10;
  localparam int PW    = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  timer_ctrl_if #(.WIDTH(WIDTH), .PRESCALE_W(PW)) bus ();

  timer_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Attached delay counter: counts ticks up to threshold, flags finished one tick later.
  logic [WIDTH-1:0] m_ctr = '0;
  logic             m_fin = 1'b0;
  always @(posedge clk) begin
    if (bus.ctr_en) begin
      if (bus.ctr_reset) begin
        m_ctr <= '0;
        m_fin <= 1'b0;
      end else if (m_ctr < bus.ctr_threshold) begin
        m_ctr <= m_ctr + 1'b1;
      end else begin
        m_fin <= 1'b1;
      end
    end
  end
  assign bus.ctr_finished = m_fin;

  int checks = 0;
  int errors = 0;

  // Observed {req_ready, busy, done, ctr_en, ctr_reset}
  function automatic logic [4:0] obs();
    return {bus.req_ready, bus.busy, bus.done, bus.ctr_en, bus.ctr_reset};
  endfunction

  // Issue a request at the current (IDLE) negedge and follow it through done and one idle cycle.
  // If keep is set, req_valid stays high with (nd, np) so it is accepted right after done.
  task automatic run_req(input int d, input int p, input bit keep, input int nd, input int np,
                         input string tag);
    int         exp_done;
    logic [4:0] exp_v;
    logic [4:0] got;
    exp_done         = (d + 1) * (p + 1) + 3;
    bus.req_valid    = 1'b1;
    bus.req_delay    = d[WIDTH-1:0];
    bus.req_prescale = p[PW-1:0];
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_at_handshake got=%b exp=1", tag, bus.req_ready);
    end
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      if (c == 1)                exp_v = 5'b01011;
      else if (c < exp_done)     exp_v = {3'b010, ((c - 2) % (p + 1)) == p, 1'b0};
      else if (c == exp_done)    exp_v = 5'b01111;
      else                       exp_v = 5'b10000;
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s ctl cycle=%0d got=%b exp=%b (rdy,busy,done,en,rst)", tag, c, got, exp_v);
      end
      if (c <= exp_done) begin
        checks++;
        if (bus.ctr_threshold !== d[WIDTH-1:0]) begin
          errors++;
          $display("FAIL %s threshold cycle=%0d got=%0d exp=%0d", tag, c, bus.ctr_threshold, d);
        end
      end
      if (c == 1) begin
        if (keep) begin
          bus.req_delay    = nd[WIDTH-1:0];
          bus.req_prescale = np[PW-1:0];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== 5'b10000 || bus.ctr_threshold !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%b thr=%0d exp=10000 thr=0", obs(), bus.ctr_threshold);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_release got=%b exp=10000", obs());
    end
  endtask

  task automatic test_min_delay();
    run_req(0, 0, 1'b0, 0, 0, "min_delay");
  endtask

  task automatic test_prescale();
    run_req(3, 1, 1'b0, 0, 0, "prescale");
    checks++;
    if (m_fin !== 1'b0) begin
      errors++;
      $display("FAIL prescale counter_finished_after_done got=%b exp=0", m_fin);
    end
  endtask

  task automatic test_back_to_back();
    run_req(4, 2, 1'b1, 7, 0, "b2b_first");
    run_req(7, 0, 1'b0, 0, 0, "b2b_second");
  endtask

  task automatic test_max_delay();
    run_req(1023, 0, 1'b0, 0, 0, "max_delay");
  endtask

  task automatic test_reset_mid_run();
    bus.req_valid    = 1'b1;
    bus.req_delay    = 10'd5;
    bus.req_prescale = '0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 5'b10000 || bus.ctr_threshold !== '0) begin
      errors++;
      $display("FAIL mid_reset_async got=%b thr=%0d exp=10000 thr=0", obs(), bus.ctr_threshold);
    end
    @(negedge clk);
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL mid_reset_hold got=%b exp=10000", obs());
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_req(2, 0, 1'b0, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    int d, p, gap;
    for (int i = 0; i < 8; i++) begin
      d   = $urandom_range(0, 40);
      p   = $urandom_range(0, 5);
      gap = $urandom_range(0, 3);
      run_req(d, p, 1'b0, 0, 0, "random");
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (obs() !== 5'b10000) begin
          errors++;
          $display("FAIL random_idle gap=%0d got=%b exp=10000", g, obs());
        end
      end
    end
  endtask

`ifdef TIMER_CTRL_ABORT_EN
  task automatic test_abort();
    bus.req_valid    = 1'b1;
    bus.req_delay    = 10'd10;
    bus.req_prescale = '0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (obs() !== 5'b01011 || bus.aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_pulse got=%b ab=%b exp=01011 ab=1", obs(), bus.aborted);
    end
    @(negedge clk);
    checks++;
    if (obs() !== 5'b10000 || bus.aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got=%b ab=%b exp=10000 ab=0", obs(), bus.aborted);
    end
    bus.req_valid    = 1'b1;
    bus.req_delay    = '0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (obs() !== 5'b01111 || bus.aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_vs_finish got=%b ab=%b exp=01111 ab=0", obs(), bus.aborted);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_delay    = '0;
    bus.req_prescale = '0;
`ifdef TIMER_CTRL_ABORT_EN
    bus.abort        = 1'b0;
`endif
    test_reset();
    test_min_delay();
    test_prescale();
    test_back_to_back();
    test_max_delay();
    test_reset_mid_run();
    test_random();
`ifdef TIMER_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
